conv55_seq_ctrl: RTL and testbench

Sequencer for a time-multiplexed 5x5, 8-bit convolution: one unsigned 8x8 multiplier and a 21-bit accumulator are shared over all 25 taps instead of 25 parallel products.
Kernel coefficients are loaded through a small config write port. Window pixels stream in one per accepted beat, raster order, tap 0 to 24. One 18-bit result per window is presented on a valid/ready output.
Sits between the line-buffer/window generator upstream and the feature-map writer downstream.

---
 rtl/conv55_pkg.sv | 23 ++
 rtl/conv55_kernel_rf.sv | 25 ++
 rtl/conv55_seq_ctrl.sv | 114 +++++++++++
 tb/tb_conv55_seq_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv55_pkg.sv
// Shared constants, state encoding and data types for the 5x5 convolution sequencer.
package conv55_pkg;
    localparam int DATA_W    = 8;
    localparam int TAPS      = 25;
    localparam int TAP_IDX_W = 5;
    localparam int ACC_W     = 21;
    localparam int OUT_W     = 18;

    localparam logic [TAP_IDX_W-1:0] LAST_TAP  = TAP_IDX_W'(TAPS - 1);
    localparam logic [TAP_IDX_W-1:0] TAP_LIMIT = TAP_IDX_W'(TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] pix_t;
    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [OUT_W-1:0]  res_t;

    localparam acc_t RES_MAX = acc_t'((1 << OUT_W) - 1);
endpackage

// File: rtl/conv55_kernel_rf.sv
// 25-entry coefficient register file: one gated write port, one combinational read port.
module conv55_kernel_rf
    import conv55_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [TAP_IDX_W-1:0] waddr,
    input  pix_t                 wdata,
    input  logic [TAP_IDX_W-1:0] raddr,
    output pix_t                 rdata
);
    pix_t regs [TAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) regs[i] <= '0;
        end else if (we && (waddr < TAP_LIMIT)) begin
            regs[waddr] <= wdata;
        end
    end

    // Addresses beyond the last tap read as zero rather than indexing past the array.
    assign rdata = (raddr < TAP_LIMIT) ? regs[raddr] : '0;
endmodule

// File: rtl/conv55_seq_ctrl.sv
// Time-multiplexed 5x5 convolution: one multiplier and accumulator shared over 25 taps.
// Build option CONV55_SAT_EN: saturate the result to OUT_W bits instead of wrapping.
module conv55_seq_ctrl
    import conv55_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [TAP_IDX_W-1:0] cfg_addr,
    input  pix_t                 cfg_data,
    output logic                 cfg_ready,
    input  logic                 clear,
    input  logic                 in_valid,
    input  pix_t                 in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 out_valid,
    output res_t                 out_data,
    input  logic                 out_ready
);
    state_t                 state, state_next;
    logic [TAP_IDX_W-1:0]   tap, tap_next;
    acc_t                   acc, acc_next, acc_sum;
    logic                   out_valid_next;
    res_t                   out_data_next, res_final;
    pix_t                   coef;
    logic [2*DATA_W-1:0]    product;

    conv55_kernel_rf u_kernel_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (cfg_we && cfg_ready),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (tap),
        .rdata (coef)
    );

    assign product = in_data * coef;
    assign acc_sum = acc + ACC_W'(product);

`ifdef CONV55_SAT_EN
    assign res_final = (acc_sum > RES_MAX) ? '1 : acc_sum[OUT_W-1:0];
`else
    assign res_final = acc_sum[OUT_W-1:0];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_next;
            tap       <= tap_next;
            acc       <= acc_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
        end
    end

    always_comb begin
        state_next     = state;
        tap_next       = tap;
        acc_next       = acc;
        out_valid_next = out_valid;
        out_data_next  = out_data;
        in_ready       = 1'b0;
        cfg_ready      = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) begin
                    acc_next   = ACC_W'(product);
                    tap_next   = TAP_IDX_W'(1);
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_next = acc_sum;
                    tap_next = tap + 1'b1;
                    if (tap == LAST_TAP) begin
                        out_valid_next = 1'b1;
                        out_data_next  = res_final;
                        state_next     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    acc_next       = '0;
                    tap_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort takes priority over any beat or handshake landing in the same cycle.
        if (clear) begin
            state_next     = IDLE;
            tap_next       = '0;
            acc_next       = '0;
            out_valid_next = 1'b0;
        end
    end
endmodule

// File: tb/tb_conv55_seq_ctrl.sv
// Directed scoreboard bench for conv55_seq_ctrl (wrap or saturating build).
module tb_conv55_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_ready;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          kmodel [25];
    longint      sb [$];

    conv55_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint reduce(input longint s);
`ifdef CONV55_SAT_EN
        return (s > 262143) ? 262143 : s;
`else
        return s % 262144;
`endif
    endfunction

    task automatic write_coef(input int addr, input int data, input bit accepted);
        cfg_we = 1'b1; cfg_addr = addr[4:0]; cfg_data = data[7:0];
        tick();
        cfg_we = 1'b0;
        if (accepted && addr < 25) kmodel[addr] = data;
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < 25; i++) write_coef(i, v, 1'b1);
    endtask

    function automatic void push_window(input int pix);
        longint s = 0;
        for (int i = 0; i < 25; i++) s += longint'(pix) * kmodel[i];
        sb.push_back(reduce(s));
    endfunction

    task automatic send_beats(input int pix, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; in_data = pix[7:0];
            tick();
            in_valid = 1'b0;
            if (gaps) tick();
        end
    endtask

    task automatic get_result(input string tag, input int hold);
        longint exp;
        int     waited = 0;
        exp = (sb.size() > 0) ? sb.pop_front() : -1;
        out_ready = 1'b0;
        while (!out_valid && waited < 60) begin
            tick();
            waited++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            for (int k = 0; k < hold; k++) begin
                check({tag, "_hold_valid"}, out_valid, 1);
                check({tag, "_hold_data"}, out_data, exp);
                tick();
            end
            check({tag, "_data"}, out_data, exp);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, out_valid, 0);
            check({tag, "_busy_drop"}, busy, 0);
            check({tag, "_in_ready_idle"}, in_ready, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 25; i++) kmodel[i] = 0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // all ones: latency and handshake
        load_all(1);
        push_window(1);
        send_beats(1, 24, 1'b0);
        check("ones_busy", busy, 1);
        check("ones_cfg_ready_accum", cfg_ready, 0);
        check("ones_no_early_valid", out_valid, 0);
        send_beats(1, 1, 1'b0);
        check("ones_latency", out_valid, 1);
        check("ones_in_ready_done", in_ready, 0);
        get_result("ones", 0);

        // full-scale: wrap vs saturate
        load_all(255);
        push_window(255);
        send_beats(255, 25, 1'b0);
        get_result("full", 0);

        // bubbles and back-pressure
        load_all(3);
        push_window(2);
        send_beats(2, 25, 1'b1);
        get_result("bubble", 3);
        tick();
        check("bubble_single_result", out_valid, 0);

        // clear with a simultaneous beat
        send_beats(5, 10, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd5;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_out_valid", out_valid, 0);
        push_window(2);
        send_beats(2, 25, 1'b0);
        get_result("clear", 0);
        repeat (3) tick();
        check("clear_one_result", out_valid, 0);

        // dropped kernel writes
        load_all(0);
        push_window(1);
        send_beats(1, 3, 1'b0);
        write_coef(7, 9, 1'b0);
        send_beats(1, 22, 1'b0);
        get_result("cfg_accum_drop", 0);
        write_coef(30, 9, 1'b0);
        push_window(1);
        send_beats(1, 25, 1'b0);
        get_result("cfg_range_drop", 0);
        write_coef(7, 9, 1'b1);
        push_window(1);
        send_beats(1, 25, 1'b0);
        get_result("cfg_idle_write", 0);

        // reset mid-window
        load_all(1);
        send_beats(1, 12, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        for (int i = 0; i < 25; i++) kmodel[i] = 0;
        #3;
        rst_n = 1'b1;
        tick();
        push_window(7);
        send_beats(7, 25, 1'b0);
        get_result("midrst_kernel_zero", 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
